stage_preif: RTL and testbench
==============================

Name: stage_preif

Overview:
- Pre-IF stage: owns the fetch PC, drives the instruction SRAM request port and hands {pc, valid} to the IF stage.
- The IF stage latches the PC and the SRAM read data in the same cycle, so this block issues each fetch address one cycle ahead.
- The block re-issues the held address while IF stalls, so the synchronous SRAM output stays valid for the held PC.
- Applies branch and exception redirects, and cancels the stale instruction latched in IF.

Parameters:
RESET_PC, 32'h1c000000, first instruction address fetched after reset release.
PC_STEP, 4, byte increment for sequential fetch.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
allowout  input  1  IF stage allowin
validout  output  1  pc/rdata pair presented to IF is a live instruction
output_pc  output  32  PC whose SRAM read is in flight (IF input_pc)
cancel  output  1  kill the instruction currently held in IF (to IF cancel)
br_taken  input  1  branch redirect from ID/EX, single-cycle pulse
br_target  input  32  branch target, valid with br_taken
br_stall  input  1  branch outcome unresolved; suppress validout while high
ex_flush  input  1  exception/ertn redirect, single-cycle pulse
ex_target  input  32  exception entry / return address
inst_sram_en  output  1  SRAM read enable
inst_sram_we  output  4  byte write enables, constant 0
inst_sram_addr  output  32  fetch address, combinational
inst_sram_wdata  output  32  constant 0

Behaviour:
- Registers:
  - state ∈ {BOOT, RUN}
  - fetch_pc[31:0]
  - fetch_valid
- Reset (async, any time incl. mid-stream):
  - state=BOOT, fetch_pc=RESET_PC, fetch_valid=0
  - outputs: validout=0, cancel=0, inst_sram_en=0 while rst high, output_pc=RESET_PC
- BOOT (first cycle after rst falls):
  - en=1, addr=RESET_PC
  - next cycle: state=RUN, fetch_pc=RESET_PC, fetch_valid=1
  - br_taken/ex_flush are ignored in BOOT because no instruction is in flight.
- RUN:
  - en=1 every cycle.
  - validout = fetch_valid & ~br_stall.
  - output_pc = fetch_pc.
- Redirect in RUN (checked each cycle):
  - redirect = ex_flush | br_taken.
  - target = ex_flush ? ex_target : br_target; ex_flush has priority.
  - On redirect: addr = target, fetch_pc <= target, fetch_valid <= 1, cancel = 1 in the same cycle.
  - The redirect takes effect regardless of allowout.
  - validout is forced to 0 that cycle so IF does not latch the wrong-path PC.
- Sequential fetch in RUN:
  - fire = validout & allowout.
  - On fire: addr = fetch_pc + PC_STEP; fetch_pc <= fetch_pc + PC_STEP.
  - Addition is mod 2^32; 32'hfffffffc wraps to 0.
- Hold in RUN:
  - no fire and no redirect (IF stalled, or br_stall high): addr = fetch_pc, fetch_pc unchanged.
  - The same address is re-read, so rdata stays coherent with output_pc.
- Latency:
  - 1 cycle from an address on inst_sram_addr to its pc appearing on output_pc with validout.
  - Sustained throughput is 1 fetch/cycle when allowout is held high.
- Simultaneous events:
  - redirect and allowout in the same cycle: the redirect wins and there is no transfer.
  - br_stall and redirect together: the redirect applies, and validout stays 0 while br_stall is high.
- Invariants:
  - inst_sram_addr[1:0] follows the target unchanged; misaligned targets are the exception unit's concern.
  - we=0 and wdata=0 always.

Test Plan:
- Reset then release, allowout=1 -> BOOT cycle: addr=0x1c000000, validout=0; following cycles: output_pc 0x1c000000, 0x1c000004, 0x1c000008 with validout=1; addr leads output_pc by 4.
- allowout=0 for 3 cycles at output_pc=0x1c000008 -> addr held at 0x1c000008, output_pc held, validout=1; allowout=1 -> next output_pc=0x1c00000c.
- br_taken=1, br_target=0x1c000100 while allowout=1 -> same cycle: cancel=1, addr=0x1c000100, validout=0; next cycle output_pc=0x1c000100, validout=1.
- ex_flush (ex_target=0x1c008000) and br_taken (0x1c000100) in the same cycle, with allowout=0 -> addr=0x1c008000, cancel=1; next output_pc=0x1c008000.
- br_stall=1 for 2 cycles -> validout=0, addr held; br_stall falls -> validout=1 with the same output_pc, no PC skipped.
- rst asserted mid-stream (output_pc=0x1c000040) -> immediately validout=0, en=0, output_pc=0x1c000000; after release the BOOT sequence repeats. Also cover a redirect to 0xfffffffc followed by a fire -> fetch_pc wraps to 0x00000000.

Source files
------------

// File: rtl/stage_preif.sv
// Pre-IF stage: owns the fetch PC and drives the instruction SRAM one cycle ahead of IF.
// Applies branch/exception redirects and re-reads the held address while IF is stalled.
module stage_preif #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        allowout,
    output logic        validout,
    output logic [31:0] output_pc,
    output logic        cancel,

    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,

    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    // Handshake: a PC moves into IF on a cycle where validout && allowout are both high.
    // validout never depends on allowout, and a redirect always suppresses the transfer.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        fetch_valid;

    logic        in_run;
    logic        redirect;
    logic        fire;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] next_addr;

    assign in_run   = (state == RUN);
    assign redirect = in_run & (ex_flush | br_taken);
    assign target   = ex_flush ? ex_target : br_target;
    assign seq_pc   = fetch_pc + PC_STEP;

    assign validout = in_run & fetch_valid & ~br_stall & ~redirect;
    assign fire     = validout & allowout;
    assign cancel   = redirect;

    // The address on the SRAM this cycle is the PC that IF will see next cycle.
    always_comb begin
        next_addr = fetch_pc;
        if (!in_run) begin
            next_addr = RESET_PC;
        end else if (redirect) begin
            next_addr = target;
        end else if (fire) begin
            next_addr = seq_pc;
        end
    end

    assign inst_sram_en    = ~rst;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = next_addr;
    assign inst_sram_wdata = 32'h0000_0000;
    assign output_pc       = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_pc    <= RESET_PC;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    fetch_pc    <= next_addr;
                    fetch_valid <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    fetch_pc    <= RESET_PC;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_preif.sv
// Bench for stage_preif: scenario tasks with inline checks, plus a scoreboard
// that pops the expected PC whenever a transfer into IF happens.
module tb_stage_preif;

    logic        clk;
    logic        rst;
    logic        allowout;
    logic        validout;
    logic [31:0] output_pc;
    logic        cancel;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_stall;
    logic        ex_flush;
    logic [31:0] ex_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    stage_preif dut (
        .clk             (clk),
        .rst             (rst),
        .allowout        (allowout),
        .validout        (validout),
        .output_pc       (output_pc),
        .cancel          (cancel),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .br_stall        (br_stall),
        .ex_flush        (ex_flush),
        .ex_target       (ex_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every transfer into IF must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && validout && allowout) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_fire pc=%h expected none", output_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (output_pc !== e) begin
                    errors++;
                    $display("FAIL scoreboard_pc got=%h exp=%h", output_pc, e);
                end
            end
        end
    end

    // driver helpers: advance to just after the next rising edge / settle before checking
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1; allowout = 1'b0; br_taken = 1'b0; br_target = '0;
        br_stall = 1'b0; ex_flush = 1'b0; ex_target = '0;
        cyc(); cyc();
        settle();
        checks++;
        if (validout !== 1'b0 || cancel !== 1'b0 || inst_sram_en !== 1'b0 || output_pc !== 32'h1c000000) begin
            errors++;
            $display("FAIL reset_outputs valid=%b cancel=%b en=%b pc=%h exp 0 0 0 1c000000",
                     validout, cancel, inst_sram_en, output_pc);
        end
        checks++;
        if (inst_sram_we !== 4'h0 || inst_sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_we_wdata we=%h wdata=%h exp 0 0", inst_sram_we, inst_sram_wdata);
        end
        cyc();
        rst = 1'b0;
        allowout = 1'b1;
        settle();
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000 || validout !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle en=%b addr=%h valid=%b exp 1 1c000000 0",
                     inst_sram_en, inst_sram_addr, validout);
        end
        exp_q.push_back(32'h1c000000);
        exp_q.push_back(32'h1c000004);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc;
            pc = 32'h1c000000 + 32'(4 * i);
            cyc();
            settle();
            checks++;
            if (output_pc !== pc || validout !== 1'b1 || inst_sram_addr !== pc + 32'd4) begin
                errors++;
                $display("FAIL seq_fetch pc=%h valid=%b addr=%h exp %h 1 %h",
                         output_pc, validout, inst_sram_addr, pc, pc + 32'd4);
            end
        end
    endtask

    task automatic test_hold();
        cyc();
        allowout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (output_pc !== 32'h1c000008 || inst_sram_addr !== 32'h1c000008 || validout !== 1'b1) begin
                errors++;
                $display("FAIL hold pc=%h addr=%h valid=%b exp 1c000008 1c000008 1",
                         output_pc, inst_sram_addr, validout);
            end
            cyc();
        end
        exp_q.push_back(32'h1c000008);
        allowout = 1'b1;
        settle();
        checks++;
        if (inst_sram_addr !== 32'h1c00000c) begin
            errors++;
            $display("FAIL hold_release_addr addr=%h exp 1c00000c", inst_sram_addr);
        end
        cyc();
        allowout = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h1c00000c || validout !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_pc pc=%h valid=%b exp 1c00000c 1", output_pc, validout);
        end
    endtask

    task automatic test_branch();
        allowout = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h1c000100;
        settle();
        checks++;
        if (cancel !== 1'b1 || inst_sram_addr !== 32'h1c000100 || validout !== 1'b0) begin
            errors++;
            $display("FAIL branch_same_cycle cancel=%b addr=%h valid=%b exp 1 1c000100 0",
                     cancel, inst_sram_addr, validout);
        end
        cyc();
        br_taken = 1'b0;
        exp_q.push_back(32'h1c000100);
        settle();
        checks++;
        if (output_pc !== 32'h1c000100 || validout !== 1'b1 || cancel !== 1'b0) begin
            errors++;
            $display("FAIL branch_next pc=%h valid=%b cancel=%b exp 1c000100 1 0",
                     output_pc, validout, cancel);
        end
        cyc();
        allowout = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h1c000104) begin
            errors++;
            $display("FAIL branch_follow pc=%h exp 1c000104", output_pc);
        end
    endtask

    task automatic test_priority();
        allowout = 1'b0;
        ex_flush = 1'b1; ex_target = 32'h1c008000;
        br_taken = 1'b1; br_target = 32'h1c000100;
        settle();
        checks++;
        if (inst_sram_addr !== 32'h1c008000 || cancel !== 1'b1 || validout !== 1'b0) begin
            errors++;
            $display("FAIL ex_priority addr=%h cancel=%b valid=%b exp 1c008000 1 0",
                     inst_sram_addr, cancel, validout);
        end
        cyc();
        ex_flush = 1'b0;
        br_taken = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h1c008000 || validout !== 1'b1) begin
            errors++;
            $display("FAIL ex_priority_next pc=%h valid=%b exp 1c008000 1", output_pc, validout);
        end
    endtask

    task automatic test_br_stall();
        allowout = 1'b1;
        br_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (validout !== 1'b0 || inst_sram_addr !== 32'h1c008000 || output_pc !== 32'h1c008000) begin
                errors++;
                $display("FAIL br_stall valid=%b addr=%h pc=%h exp 0 1c008000 1c008000",
                         validout, inst_sram_addr, output_pc);
            end
            cyc();
        end
        br_stall = 1'b0;
        exp_q.push_back(32'h1c008000);
        settle();
        checks++;
        if (validout !== 1'b1 || output_pc !== 32'h1c008000 || inst_sram_addr !== 32'h1c008004) begin
            errors++;
            $display("FAIL br_stall_release valid=%b pc=%h addr=%h exp 1 1c008000 1c008004",
                     validout, output_pc, inst_sram_addr);
        end
        cyc();
        allowout = 1'b0;
        // redirect while br_stall is high still applies
        br_stall = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h1c000200;
        settle();
        checks++;
        if (inst_sram_addr !== 32'h1c000200 || cancel !== 1'b1 || validout !== 1'b0) begin
            errors++;
            $display("FAIL stall_redirect addr=%h cancel=%b valid=%b exp 1c000200 1 0",
                     inst_sram_addr, cancel, validout);
        end
        cyc();
        br_taken = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h1c000200 || validout !== 1'b0) begin
            errors++;
            $display("FAIL stall_redirect_next pc=%h valid=%b exp 1c000200 0", output_pc, validout);
        end
        br_stall = 1'b0;
    endtask

    task automatic test_random_flow();
        logic [31:0] pc;
        pc = 32'h1c000200;
        for (int i = 0; i < 20; i++) begin
            logic a;
            a = 1'($urandom_range(0, 1));
            allowout = a;
            if (a) exp_q.push_back(pc);
            settle();
            checks++;
            if (inst_sram_addr !== (a ? pc + 32'd4 : pc) || output_pc !== pc) begin
                errors++;
                $display("FAIL random_flow addr=%h pc=%h exp addr=%h pc=%h",
                         inst_sram_addr, output_pc, a ? pc + 32'd4 : pc, pc);
            end
            cyc();
            if (a) pc = pc + 32'd4;
        end
        allowout = 1'b0;
    endtask

    task automatic test_reset_mid();
        br_taken = 1'b1;
        br_target = 32'h1c000040;
        cyc();
        br_taken = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h1c000040 || validout !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup pc=%h valid=%b exp 1c000040 1", output_pc, validout);
        end
        cyc();
        allowout = 1'b1;
        rst = 1'b1;
        settle();
        checks++;
        if (validout !== 1'b0 || inst_sram_en !== 1'b0 || output_pc !== 32'h1c000000 || cancel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%b en=%b pc=%h cancel=%b exp 0 0 1c000000 0",
                     validout, inst_sram_en, output_pc, cancel);
        end
        cyc();
        rst = 1'b0;
        settle();
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000 || validout !== 1'b0) begin
            errors++;
            $display("FAIL mid_boot en=%b addr=%h valid=%b exp 1 1c000000 0",
                     inst_sram_en, inst_sram_addr, validout);
        end
        exp_q.push_back(32'h1c000000);
        cyc();
        allowout = 1'b1;
        settle();
        checks++;
        if (output_pc !== 32'h1c000000 || validout !== 1'b1) begin
            errors++;
            $display("FAIL mid_reboot pc=%h valid=%b exp 1c000000 1", output_pc, validout);
        end
        cyc();
        allowout = 1'b0;
    endtask

    task automatic test_wrap();
        allowout = 1'b1;
        br_taken = 1'b1;
        br_target = 32'hfffffffc;
        settle();
        checks++;
        if (inst_sram_addr !== 32'hfffffffc) begin
            errors++;
            $display("FAIL wrap_redirect addr=%h exp fffffffc", inst_sram_addr);
        end
        cyc();
        br_taken = 1'b0;
        exp_q.push_back(32'hfffffffc);
        settle();
        checks++;
        if (output_pc !== 32'hfffffffc || inst_sram_addr !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_fire pc=%h addr=%h exp fffffffc 00000000", output_pc, inst_sram_addr);
        end
        cyc();
        allowout = 1'b0;
        settle();
        checks++;
        if (output_pc !== 32'h00000000 || validout !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc pc=%h valid=%b exp 00000000 1", output_pc, validout);
        end
        // misaligned target passes through untouched
        ex_flush = 1'b1;
        ex_target = 32'h1c000102;
        settle();
        checks++;
        if (inst_sram_addr !== 32'h1c000102) begin
            errors++;
            $display("FAIL misaligned_addr addr=%h exp 1c000102", inst_sram_addr);
        end
        cyc();
        ex_flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_branch();
        test_priority();
        test_br_stall();
        test_random_flow();
        test_reset_mid();
        test_wrap();
        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
